// File: rtl/rgb_pwm_driver.sv
// Three-channel active-low PWM stage with double-buffered duties applied at the period wrap.
// Optional RGB_PWM_STAGGER_EN offsets the green/blue phases by STAGGER/2*STAGGER cycles.
module rgb_pwm_driver #(
  parameter int PWM_INTERVAL = 1200,
  parameter int VAL_W        = 11,
  parameter int STAGGER      = 400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] r_val,
  input  logic [VAL_W-1:0] g_val,
  input  logic [VAL_W-1:0] b_val,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             period_start,
  output logic             RGB_R,
  output logic             RGB_G,
  output logic             RGB_B
);

  localparam int CW = $clog2(PWM_INTERVAL);
  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_INTERVAL - 1);

`ifdef RGB_PWM_STAGGER_EN
  localparam int STAGGER_EN = 1;
  if (2 * STAGGER >= PWM_INTERVAL) begin : g_bad_stagger
    $error("rgb_pwm_driver: 2*STAGGER must be less than PWM_INTERVAL");
  end
`else
  localparam int STAGGER_EN = 0;
`endif

  localparam int OFF_G = STAGGER * STAGGER_EN;
  localparam int OFF_B = 2 * STAGGER * STAGGER_EN;

  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_pend_r, r_pend_g, r_pend_b;
  logic [DW-1:0] r_duty_r, r_duty_g, r_duty_b;
  logic          r_pending;
  logic          r_period_start;
  logic          r_rgb_r, r_rgb_g, r_rgb_b;

  logic          w_wrap;
  logic          w_xfer;
  logic [CW-1:0] w_phase_r, w_phase_g, w_phase_b;
  logic          w_on_r, w_on_g, w_on_b;

  // Values at or above the period length saturate to "always on".
  function automatic logic [DW-1:0] clamp(input logic [VAL_W-1:0] v);
    if (32'(v) >= 32'(PWM_INTERVAL)) return DW'(PWM_INTERVAL);
    else                             return DW'(v);
  endfunction

  // cnt < PWM_INTERVAL and off < PWM_INTERVAL, so one conditional subtract is a full modulo.
  function automatic logic [CW-1:0] phase_add(input logic [CW-1:0] c, input int off);
    int s;
    s = int'(c) + off;
    if (s >= PWM_INTERVAL) s = s - PWM_INTERVAL;
    return CW'(s);
  endfunction

  assign w_wrap     = (r_cnt == CNT_LAST);
  assign load_ready = ~r_pending;
  assign w_xfer     = load_valid & ~r_pending;

  assign w_phase_r = r_cnt;
  assign w_phase_g = phase_add(r_cnt, OFF_G);
  assign w_phase_b = phase_add(r_cnt, OFF_B);

  assign w_on_r = (DW'(w_phase_r) < r_duty_r);
  assign w_on_g = (DW'(w_phase_g) < r_duty_g);
  assign w_on_b = (DW'(w_phase_b) < r_duty_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_wrap ? '0 : r_cnt + 1'b1;
      r_period_start <= w_wrap;
    end
  end

  // A transfer can only happen with pending clear, and an apply only with pending set,
  // so the two never compete for the pending flag in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_pend_r  <= '0;
      r_pend_g  <= '0;
      r_pend_b  <= '0;
      r_duty_r  <= '0;
      r_duty_g  <= '0;
      r_duty_b  <= '0;
    end else if (w_xfer) begin
      r_pending <= 1'b1;
      r_pend_r  <= clamp(r_val);
      r_pend_g  <= clamp(g_val);
      r_pend_b  <= clamp(b_val);
    end else if (w_wrap && r_pending) begin
      r_pending <= 1'b0;
      r_duty_r  <= r_pend_r;
      r_duty_g  <= r_pend_g;
      r_duty_b  <= r_pend_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb_r <= 1'b1;
      r_rgb_g <= 1'b1;
      r_rgb_b <= 1'b1;
    end else begin
      r_rgb_r <= ~w_on_r;
      r_rgb_g <= ~w_on_g;
      r_rgb_b <= ~w_on_b;
    end
  end

  assign period_start = r_period_start;
  assign RGB_R        = r_rgb_r;
  assign RGB_G        = r_rgb_g;
  assign RGB_B        = r_rgb_b;

endmodule
